// File: rtl/clk_step_pkg.sv
// Shared encodings for the slow-clock run controller.
// Mode codes, FSM states and default widths.
package clk_step_pkg;

  localparam int CNT_W_DEF       = 25;
  localparam int BURST_W_DEF     = 16;
  localparam int DEFAULT_DIV_DEF = 10;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_BURST,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  function automatic logic is_active(state_t s);
    return (s == ST_RUN) || (s == ST_STEP) ||
           (s == ST_BURST) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable divider: 50% clock plus a tick on each rising toggle.
// Held at the reload value whenever disabled or cleared.
module tick_divider #(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] div_q,
  output logic             clkout,
  output logic             tick,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == '0);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= CNT_W'(DEFAULT_DIV);
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else if (!en || clear) begin
      cnt    <= div_q;
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else if (last) begin
      cnt    <= div_q;
      clkout <= ~clkout;
      tick   <= ~clkout;
    end else begin
      cnt    <= cnt - 1'b1;
      tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run-control scheduler for the processor slow clock:
// halt / free-run / single-step / N-step burst over a divider.
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int BURST_W     = BURST_W_DEF
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   div_val,
  input  logic               div_load,
  input  logic               step_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  output logic               clkout,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [CNT_W-1:0]   div_q;
  logic [BURST_W-1:0] remaining;
  logic               step_q;
  logic               halt_pend;
  logic               en;
  logic               clear;
  logic               last;
  logic               step_rise;

  assign en        = is_active(state);
  assign step_rise = step_req & ~step_q;

  // Stops taken while clkout is low must also swallow a same-edge rise.
  assign clear = en & ~clkout & (halt_req | (state == ST_DRAIN));

  tick_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_div (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .en     (en),
    .clear  (clear),
    .div_q  (div_q),
    .clkout (clkout),
    .tick   (tick),
    .last   (last)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_q     <= CNT_W'(DEFAULT_DIV);
      remaining <= '0;
      step_q    <= 1'b0;
      halt_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      step_q <= step_req;
      done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (div_load) div_q <= div_val;
          unique case (1'b1)
            (mode == MODE_RUN): begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
            (step_rise && mode == MODE_STEP): begin
              state <= ST_STEP;
              busy  <= 1'b1;
            end
            (step_rise && mode == MODE_BURST &&
             burst_len != '0): begin
              state     <= ST_BURST;
              busy      <= 1'b1;
              remaining <= burst_len;
            end
            (step_rise && mode == MODE_BURST &&
             burst_len == '0): begin
              done <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_HALTED: begin
          if (div_load) div_q <= div_val;
          if (mode == MODE_HALT && !halt_req)
            state <= ST_IDLE;
        end
        default: begin
          if (halt_req || halt_pend) begin
            if (!clkout || last) begin
              state     <= ST_HALTED;
              busy      <= 1'b0;
              halt_pend <= 1'b0;
            end else begin
              state     <= ST_DRAIN;
              halt_pend <= 1'b1;
            end
          end else begin
            unique case (state)
              ST_RUN: begin
                if (mode != MODE_RUN)
                  state <= ST_DRAIN;
              end
              ST_STEP: begin
                if (last && clkout) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
              ST_BURST: begin
                if (last && clkout && remaining == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else if (last && !clkout) begin
                  remaining <= remaining - 1'b1;
                end
              end
              ST_DRAIN: begin
                if (!clkout || last) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: vector table of run/step/burst
// scenarios plus hand sequences for halt, held step and reset.
module tb_clk_step_ctrl;
  import clk_step_pkg::*;

  localparam int CW = 25;
  localparam int BW = 16;

  logic          clkin = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] div_val = '0;
  logic          div_load = 1'b0;
  logic          step_req = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          halt_req = 1'b0;
  logic          clkout;
  logic          tick;
  logic          busy;
  logic          done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int tick_q[$];
  int done_q[$];
  int te;
  int de;

  typedef struct {
    logic [1:0] mode;
    int         div;
    int         blen;
    bit         mid_load;
    int         nticks;
    int         first;
    int         period;
    int         done_dly;
    logic       busy;
  } vec_t;

  vec_t vecs[11];

  clk_step_ctrl dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .mode      (mode),
    .div_val   (div_val),
    .div_load  (div_load),
    .step_req  (step_req),
    .burst_len (burst_len),
    .halt_req  (halt_req),
    .clkout    (clkout),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  always @(negedge clkin) begin
    if (rst_n && tick) begin
      checks++;
      if (tick_q.size() == 0) begin
        errors++;
        $display("FAIL tick_extra: tick at cyc=%0d, want none", cyc);
      end else begin
        te = tick_q.pop_front();
        if (te != cyc) begin
          errors++;
          $display("FAIL tick_time: got cyc=%0d want cyc=%0d", cyc, te);
        end
      end
    end
    if (rst_n && done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_extra: done at cyc=%0d, want none", cyc);
      end else begin
        de = done_q.pop_front();
        if (de != cyc) begin
          errors++;
          $display("FAIL done_time: got cyc=%0d want cyc=%0d", cyc, de);
        end
      end
    end
  end

  task automatic step_cyc(input int n = 1);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic load_div(input int d);
    div_val  = CW'(d);
    div_load = 1'b1;
    step_cyc();
    div_load = 1'b0;
    step_cyc();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((tick_q.size() != 0 || done_q.size() != 0) && n < 2000) begin
      step_cyc();
      n++;
    end
    check({name, "_drained"}, tick_q.size() + done_q.size(), 0);
    tick_q.delete();
    done_q.delete();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int e;
    int t;
    load_div(v.div);
    burst_len = BW'(v.blen);
    mode = v.mode;
    e = cyc + 1;
    for (int i = 0; i < v.nticks; i++)
      tick_q.push_back(e + v.first + i * v.period);
    if (v.done_dly >= 0) done_q.push_back(e + v.done_dly);
    if (v.mode != MODE_RUN) step_req = 1'b1;
    step_cyc();
    check($sformatf("v%0d_busy_entry", idx), busy, v.busy);
    step_req = 1'b0;
    if (v.mid_load) begin
      div_val  = CW'(7);
      div_load = 1'b1;
      step_cyc();
      div_load = 1'b0;
    end
    if (v.mode == MODE_RUN) begin
      t = e + v.first + (v.nticks - 1) * v.period;
      while (cyc < t) step_cyc();
      mode = MODE_HALT;
    end
    wait_drain($sformatf("v%0d", idx));
    step_cyc(2 * (v.div + 1) + 3);
    check($sformatf("v%0d_busy_end", idx), busy, 0);
    check($sformatf("v%0d_clk_end", idx), clkout, 0);
    mode = MODE_HALT;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int t;
    vecs[0]  = '{MODE_RUN,   3, 0, 1'b0, 3, 4,  8, -1, 1'b1};
    vecs[1]  = '{MODE_STEP,  3, 0, 1'b0, 1, 4,  8,  8, 1'b1};
    vecs[2]  = '{MODE_BURST, 1, 5, 1'b0, 5, 2,  4, 20, 1'b1};
    vecs[3]  = '{MODE_BURST, 1, 0, 1'b0, 0, 0,  0,  0, 1'b0};
    vecs[4]  = '{MODE_RUN,   0, 0, 1'b0, 4, 1,  2, -1, 1'b1};
    vecs[5]  = '{MODE_BURST, 2, 2, 1'b0, 2, 3,  6, 12, 1'b1};
    vecs[6]  = '{MODE_STEP,  0, 0, 1'b0, 1, 1,  2,  2, 1'b1};
    vecs[7]  = '{MODE_BURST, 0, 1, 1'b0, 1, 1,  2,  2, 1'b1};
    vecs[8]  = '{MODE_RUN,   3, 0, 1'b1, 3, 4,  8, -1, 1'b1};
    vecs[9]  = '{MODE_RUN,   7, 0, 1'b0, 2, 8, 16, -1, 1'b1};
    vecs[10] = '{MODE_BURST, 3, 3, 1'b0, 3, 4,  8, 24, 1'b1};

    step_cyc(2);
    check("rst_clkout", clkout, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step_cyc(2);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // held step_req yields a single step
    load_div(3);
    mode = MODE_STEP;
    e = cyc + 1;
    tick_q.push_back(e + 4);
    done_q.push_back(e + 8);
    step_req = 1'b1;
    step_cyc(20);
    step_req = 1'b0;
    wait_drain("held_step");
    step_cyc(12);
    check("held_step_busy", busy, 0);
    mode = MODE_HALT;
    step_cyc(2);

    // halt while clkout high finishes the high phase
    load_div(2);
    mode = MODE_RUN;
    e = cyc + 1;
    t = e + 3;
    tick_q.push_back(t);
    while (cyc < t) step_cyc();
    halt_req = 1'b1;
    step_cyc(2);
    check("halt_high_hold", clkout, 1);
    step_cyc();
    check("halt_fall", clkout, 0);
    check("halt_busy", busy, 0);
    step_cyc(10);
    wait_drain("halt");
    halt_req = 1'b0;
    step_cyc(10);
    check("halted_run_ignored", busy, 0);

    // load in HALTED, then exit and halt again with clkout low
    load_div(0);
    mode = MODE_HALT;
    step_cyc(2);
    mode = MODE_RUN;
    halt_req = 1'b1;
    step_cyc();
    check("halt_now_entry_busy", busy, 1);
    step_cyc();
    check("halt_now_busy", busy, 0);
    step_cyc(5);
    halt_req = 1'b0;
    mode = MODE_HALT;
    step_cyc(3);

    mode = MODE_STEP;
    e = cyc + 1;
    tick_q.push_back(e + 1);
    done_q.push_back(e + 2);
    step_req = 1'b1;
    step_cyc();
    step_req = 1'b0;
    wait_drain("halted_load");
    step_cyc(4);
    mode = MODE_HALT;

    // reset in the middle of a burst with three ticks left
    load_div(1);
    burst_len = BW'(5);
    mode = MODE_BURST;
    e = cyc + 1;
    tick_q.push_back(e + 2);
    tick_q.push_back(e + 6);
    step_req = 1'b1;
    step_cyc();
    step_req = 1'b0;
    while (cyc < e + 7) step_cyc();
    check("rst_mid_pre_clk", clkout, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clkout", clkout, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tick", tick, 0);
    check("rst_mid_done", done, 0);
    step_cyc(2);
    rst_n = 1'b1;
    check("rst_mid_q", tick_q.size(), 0);
    step_cyc(30);
    check("rst_mid_idle", busy, 0);

    mode = MODE_STEP;
    e = cyc + 1;
    tick_q.push_back(e + 11);
    done_q.push_back(e + 22);
    step_req = 1'b1;
    step_cyc();
    step_req = 1'b0;
    wait_drain("rst_default_div");
    step_cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
